// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg
//   Shared types and helpers for the system-bus fabric.
//   - own_state_t : bus ownership states (CPU_OWN, HALT_WAIT, DMA_OWN, RELEASE)
//   - SEL_W/SEL_NONE : width and "no device selected" code of the registered
//     read-return select; SEL_NONE lies outside the 0..15 device range.
//   - region_hit  : masked address compare used by every region decoder.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        CPU_OWN,
        HALT_WAIT,
        DMA_OWN,
        RELEASE
    } own_state_t;

    localparam int SEL_W = 5;
    localparam logic [SEL_W-1:0] SEL_NONE = '1;

    // Operands are widened to 32 bits so one function serves any ADDR_W <= 32.
    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/sys_bus_fabric_if.sv
// sys_bus_fabric_if
//   Bundles the CPU, DMA (MARIA) and slave-side signals of the system bus.
//   Modports:
//     master : the bus environment (CPU wrapper, DMA master, slave read data)
//     slave  : the fabric itself (decodes, arbitrates, returns read data)
//   Signals:
//     cpu_addr/cpu_wdata/cpu_rw/cpu_sync  CPU request and haltable-cycle flag
//     cpu_halt_n                          0 = CPU must stall
//     dma_req/dma_addr/dma_done           DMA bus request, address, burst end
//     dma_grant                           DMA owns the bus
//     bus_addr/bus_rw                     muxed address and rw to slaves
//     dev_cs                              one-hot chip selects
//     dev_rdata                           packed slave read data
//     rdata                               returned read data
interface sys_bus_fabric_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int N_DEV  = 8
);

    logic [ADDR_W-1:0]       cpu_addr;
    logic [DATA_W-1:0]       cpu_wdata;
    logic                    cpu_rw;
    logic                    cpu_sync;
    logic                    cpu_halt_n;
    logic                    dma_req;
    logic [ADDR_W-1:0]       dma_addr;
    logic                    dma_done;
    logic                    dma_grant;
    logic [ADDR_W-1:0]       bus_addr;
    logic                    bus_rw;
    logic [N_DEV-1:0]        dev_cs;
    logic [N_DEV*DATA_W-1:0] dev_rdata;
    logic [DATA_W-1:0]       rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_rw, cpu_sync,
        output dma_req, dma_addr, dma_done,
        output dev_rdata,
        input  cpu_halt_n, dma_grant, bus_addr, bus_rw, dev_cs, rdata
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rw, cpu_sync,
        input  dma_req, dma_addr, dma_done,
        input  dev_rdata,
        output cpu_halt_n, dma_grant, bus_addr, bus_rw, dev_cs, rdata
    );

endinterface

// File: rtl/bus_own_fsm.sv
// bus_own_fsm
//   Bus ownership handshake between the CPU and the DMA master.
//   The CPU is halted first and the DMA master is granted only once the CPU
//   reports a haltable cycle boundary; after the burst one RELEASE cycle
//   keeps the CPU halted while the bus settles back to the CPU side.
//   Ports:
//     memclk    in   bus clock
//     reset     in   asynchronous, active-high
//     dma_req   in   DMA master requests the bus
//     cpu_sync  in   CPU is at a haltable cycle boundary
//     dma_done  in   single-cycle end-of-burst pulse
//     state_q   out  current ownership state
//     halt_n_q  out  registered CPU halt (0 = stall)
//     grant_q   out  registered DMA grant
module bus_own_fsm
    import sys_bus_pkg::*;
(
    input  logic       memclk,
    input  logic       reset,
    input  logic       dma_req,
    input  logic       cpu_sync,
    input  logic       dma_done,
    output own_state_t state_q,
    output logic       halt_n_q,
    output logic       grant_q
);

    // Outputs are set on the transition into each state so they are glitch
    // free flops; a request and sync arriving together still pass through
    // HALT_WAIT for at least one cycle.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            state_q  <= CPU_OWN;
            halt_n_q <= 1'b1;
            grant_q  <= 1'b0;
        end else begin
            case (state_q)
                CPU_OWN: begin
                    if (dma_req) begin
                        state_q  <= HALT_WAIT;
                        halt_n_q <= 1'b0;
                    end
                end
                HALT_WAIT: begin
                    if (!dma_req) begin
                        state_q  <= CPU_OWN;
                        halt_n_q <= 1'b1;
                    end else if (cpu_sync) begin
                        state_q <= DMA_OWN;
                        grant_q <= 1'b1;
                    end
                end
                DMA_OWN: begin
                    if (dma_done) begin
                        state_q <= RELEASE;
                        grant_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    // A pending request skips the CPU slot and halts again.
                    if (dma_req) begin
                        state_q <= HALT_WAIT;
                    end else begin
                        state_q  <= CPU_OWN;
                        halt_n_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= CPU_OWN;
                    halt_n_q <= 1'b1;
                    grant_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sys_bus_fabric.sv
// sys_bus_fabric
//   Generic system-bus fabric between the 6502 wrapper, the MARIA DMA master
//   and all memory/IO slaves: N_DEV region decoder, CPU/DMA ownership
//   handshake, registered read-return select and a lockable control register.
//   Ports:
//     memclk       in   bus clock
//     reset        in   asynchronous, active-high
//     bus          if   sys_bus_fabric_if.slave (CPU, DMA and slave signals)
//     ctrl_q       out  control register, bit0 = lock
//     ctrl_writes  out  accepted control writes, saturating at WR_SAT
//   Configuration macro:
//     OPEN_BUS_EN  unmapped reads return the last mapped read data instead
//                  of DEFAULT_DATA.
module sys_bus_fabric
    import sys_bus_pkg::*;
#(
    parameter int                      ADDR_W       = 16,
    parameter int                      DATA_W       = 8,
    parameter int                      N_DEV        = 8,
    parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE     = {16'h4000, 16'h0000, 16'h0280, 16'hC000,
                                                       16'h8000, 16'h4000, 16'h1800, 16'h2000},
    parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK     = {16'hF000, 16'hFF00, 16'hFF80, 16'hC000,
                                                       16'hC000, 16'hC000, 16'hF800, 16'hE000},
    parameter logic [ADDR_W-1:0]       CTRL_BASE    = 16'h0000,
    parameter logic [ADDR_W-1:0]       CTRL_MASK    = 16'hFFE0,
    parameter int                      CTRL_W       = 4,
    parameter int                      WR_SAT       = 2,
    parameter logic [DATA_W-1:0]       DEFAULT_DATA = 8'h46
)(
    input  logic                          memclk,
    input  logic                          reset,
    sys_bus_fabric_if.slave               bus,
    output logic [CTRL_W-1:0]             ctrl_q,
    output logic [$clog2(WR_SAT+1)-1:0]   ctrl_writes
);

    localparam int CNT_W = $clog2(WR_SAT + 1);

    own_state_t        own_state;
    logic              fsm_halt_n;
    logic              fsm_grant;
    logic [ADDR_W-1:0] mux_addr;
    logic              mux_rw;
    logic              found;
    logic [SEL_W-1:0]  win_idx;
    logic [N_DEV-1:0]  cs;
    logic [SEL_W-1:0]  sel_d, sel_q;
    logic              mapped;
    logic [DATA_W-1:0] mapped_data;
    logic [DATA_W-1:0] rdata_mux;
    logic              ctrl_wr;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CNT_W-1:0]  writes_d, writes_q;
`ifdef OPEN_BUS_EN
    logic [DATA_W-1:0] open_d, open_q;
`endif

    bus_own_fsm u_own_fsm (
        .memclk   (memclk),
        .reset    (reset),
        .dma_req  (bus.dma_req),
        .cpu_sync (bus.cpu_sync),
        .dma_done (bus.dma_done),
        .state_q  (own_state),
        .halt_n_q (fsm_halt_n),
        .grant_q  (fsm_grant)
    );

    // The DMA master only reads, so rw is forced high while it owns the bus.
    always_comb begin
        mux_addr = fsm_grant ? bus.dma_addr : bus.cpu_addr;
        mux_rw   = fsm_grant ? 1'b1 : bus.cpu_rw;
    end

    // Lowest-index hit wins. Writes into the control window are consumed by
    // the fabric, so no slave is selected even if a region overlaps it.
    always_comb begin
        found   = 1'b0;
        win_idx = SEL_NONE;
        for (int i = 0; i < N_DEV; i++) begin
            if (!found && region_hit(32'(mux_addr),
                                     32'(DEV_BASE[i*ADDR_W +: ADDR_W]),
                                     32'(DEV_MASK[i*ADDR_W +: ADDR_W]))) begin
                found   = 1'b1;
                win_idx = SEL_W'(i);
            end
        end
        if (!mux_rw && region_hit(32'(mux_addr), 32'(CTRL_BASE), 32'(CTRL_MASK))) begin
            found   = 1'b0;
            win_idx = SEL_NONE;
        end
        cs = '0;
        for (int i = 0; i < N_DEV; i++) begin
            cs[i] = found && (win_idx == SEL_W'(i));
        end
        sel_d = win_idx;
    end

    // Read data returns one cycle after the address phase via sel_q.
    always_comb begin
        mapped      = 1'b0;
        mapped_data = DEFAULT_DATA;
        for (int i = 0; i < N_DEV; i++) begin
            if (sel_q == SEL_W'(i)) begin
                mapped      = 1'b1;
                mapped_data = bus.dev_rdata[i*DATA_W +: DATA_W];
            end
        end
`ifdef OPEN_BUS_EN
        open_d    = mapped ? mapped_data : open_q;
        rdata_mux = mapped ? mapped_data : open_q;
`else
        rdata_mux = mapped ? mapped_data : DEFAULT_DATA;
`endif
    end

    // Only the CPU can write the control register, and only while unlocked;
    // once bit0 is set the register and its write count freeze until reset.
    always_comb begin
        ctrl_d   = ctrl_q;
        writes_d = writes_q;
        ctrl_wr  = (own_state == CPU_OWN) && !bus.cpu_rw && !ctrl_q[0] &&
                   region_hit(32'(bus.cpu_addr), 32'(CTRL_BASE), 32'(CTRL_MASK));
        if (ctrl_wr) begin
            ctrl_d = bus.cpu_wdata[CTRL_W-1:0];
            if (writes_q != CNT_W'(WR_SAT)) begin
                writes_d = writes_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            sel_q    <= SEL_NONE;
            ctrl_q   <= '0;
            writes_q <= '0;
`ifdef OPEN_BUS_EN
            open_q   <= DEFAULT_DATA;
`endif
        end else begin
            sel_q    <= sel_d;
            ctrl_q   <= ctrl_d;
            writes_q <= writes_d;
`ifdef OPEN_BUS_EN
            open_q   <= open_d;
`endif
        end
    end

    assign bus.cpu_halt_n = fsm_halt_n;
    assign bus.dma_grant  = fsm_grant;
    assign bus.bus_addr   = mux_addr;
    assign bus.bus_rw     = mux_rw;
    assign bus.dev_cs     = cs;
    assign bus.rdata      = rdata_mux;
    assign ctrl_writes    = writes_q;

endmodule

// File: tb/tb_sys_bus_fabric.sv
// tb_sys_bus_fabric
//   Self-checking bench for sys_bus_fabric: a table of decode vectors with a
//   read-data scoreboard, then hand-written ownership, control-register and
//   reset sequences. Honours OPEN_BUS_EN for the unmapped-read expectation.
module tb_sys_bus_fabric;

    localparam logic [7:0] DEFAULT_DATA = 8'h46;
`ifdef OPEN_BUS_EN
    localparam bit OPEN_BUS = 1'b1;
`else
    localparam bit OPEN_BUS = 1'b0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic [7:0]  exp_cs;
        int          exp_idx;
    } vec_t;

    logic       memclk = 1'b0;
    logic       reset;
    logic [3:0] ctrl_q;
    logic [1:0] ctrl_writes;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [7:0] exp_q[$];
    logic [7:0] open_last;
    logic [7:0] dev_data [8] = '{8'h10, 8'hA5, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    vec_t       vecs [12];

    always #5 memclk = ~memclk;

    sys_bus_fabric_if #(.ADDR_W(16), .DATA_W(8), .N_DEV(8)) bus ();

    sys_bus_fabric dut (
        .memclk      (memclk),
        .reset       (reset),
        .bus         (bus),
        .ctrl_q      (ctrl_q),
        .ctrl_writes (ctrl_writes)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drives one table vector, checks the combinational chip selects and
    // queues the read data the model predicts for the next cycle.
    task automatic applyStimulus(input vec_t v);
        logic [7:0] e;
        @(negedge memclk);
        bus.cpu_addr  = v.addr;
        bus.cpu_rw    = v.rw;
        bus.cpu_wdata = v.wdata;
        #1;
        checkOutput($sformatf("dev_cs@%h", v.addr), 32'(bus.dev_cs), 32'(v.exp_cs));
        if (v.exp_idx >= 0) e = dev_data[v.exp_idx];
        else                e = OPEN_BUS ? open_last : DEFAULT_DATA;
        exp_q.push_back(e);
        if (v.exp_idx >= 0) open_last = dev_data[v.exp_idx];
    endtask

    task automatic scoreboardPop(input logic [15:0] addr);
        @(posedge memclk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            checkOutput($sformatf("rdata@%h", addr), 32'(bus.rdata), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge memclk);
        @(negedge memclk);
        reset = 1'b0;
        open_last = DEFAULT_DATA;
    endtask

    task automatic step();
        @(posedge memclk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'h1800, 1'b1, 8'h00, 8'h02,  1};
        vecs[1]  = '{16'h0480, 1'b1, 8'h00, 8'h00, -1};
        vecs[2]  = '{16'h2000, 1'b1, 8'h00, 8'h01,  0};
        vecs[3]  = '{16'h4100, 1'b1, 8'h00, 8'h04,  2};
        vecs[4]  = '{16'h8ABC, 1'b1, 8'h00, 8'h08,  3};
        vecs[5]  = '{16'hC000, 1'b1, 8'h00, 8'h10,  4};
        vecs[6]  = '{16'h02FF, 1'b1, 8'h00, 8'h20,  5};
        vecs[7]  = '{16'h0010, 1'b1, 8'h00, 8'h40,  6};
        vecs[8]  = '{16'h0010, 1'b0, 8'h00, 8'h00, -1};
        vecs[9]  = '{16'h0300, 1'b1, 8'h00, 8'h00, -1};
        vecs[10] = '{16'h1FFF, 1'b0, 8'h55, 8'h02,  1};
        vecs[11] = '{16'h3FFF, 1'b1, 8'h00, 8'h01,  0};

        bus.cpu_addr  = 16'h0480;
        bus.cpu_wdata = 8'h00;
        bus.cpu_rw    = 1'b1;
        bus.cpu_sync  = 1'b0;
        bus.dma_req   = 1'b0;
        bus.dma_addr  = 16'h0000;
        bus.dma_done  = 1'b0;
        for (int i = 0; i < 8; i++) bus.dev_rdata[i*8 +: 8] = dev_data[i];
        doReset();

        checkOutput("reset_halt_n", 32'(bus.cpu_halt_n), 32'd1);
        checkOutput("reset_grant", 32'(bus.dma_grant), 32'd0);
        checkOutput("reset_rdata", 32'(bus.rdata), 32'(DEFAULT_DATA));
        checkOutput("reset_ctrl_q", 32'(ctrl_q), 32'd0);
        checkOutput("reset_ctrl_writes", 32'(ctrl_writes), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            scoreboardPop(vecs[i].addr);
        end

        // Ownership handover with a CPU that takes three cycles to sync.
        @(negedge memclk);
        bus.cpu_addr = 16'h0480;
        bus.cpu_rw   = 1'b0;
        bus.dma_addr = 16'h1234;
        bus.dma_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("halt_wait_halt_n", 32'(bus.cpu_halt_n), 32'd0);
            checkOutput("halt_wait_grant", 32'(bus.dma_grant), 32'd0);
        end
        @(negedge memclk);
        bus.cpu_sync = 1'b1;
        step();
        checkOutput("dma_own_grant", 32'(bus.dma_grant), 32'd1);
        checkOutput("dma_own_halt_n", 32'(bus.cpu_halt_n), 32'd0);
        checkOutput("dma_own_bus_addr", 32'(bus.bus_addr), 32'h1234);
        checkOutput("dma_own_bus_rw", 32'(bus.bus_rw), 32'd1);
        @(negedge memclk);
        bus.cpu_sync = 1'b0;
        bus.dma_done = 1'b1;
        bus.dma_req  = 1'b0;
        step();
        checkOutput("release_grant", 32'(bus.dma_grant), 32'd0);
        checkOutput("release_halt_n", 32'(bus.cpu_halt_n), 32'd0);
        checkOutput("release_bus_addr", 32'(bus.bus_addr), 32'h0480);
        @(negedge memclk);
        bus.dma_done = 1'b0;
        step();
        checkOutput("cpu_own_halt_n", 32'(bus.cpu_halt_n), 32'd1);
        checkOutput("cpu_own_grant", 32'(bus.dma_grant), 32'd0);

        // Request and sync together must still pass through HALT_WAIT.
        @(negedge memclk);
        bus.dma_req  = 1'b1;
        bus.cpu_sync = 1'b1;
        step();
        checkOutput("simul_no_grant", 32'(bus.dma_grant), 32'd0);
        checkOutput("simul_halt_n", 32'(bus.cpu_halt_n), 32'd0);
        step();
        checkOutput("simul_grant", 32'(bus.dma_grant), 32'd1);

        // Request held through RELEASE goes straight back to HALT_WAIT.
        @(negedge memclk);
        bus.cpu_sync = 1'b0;
        bus.dma_done = 1'b1;
        step();
        checkOutput("rereq_release_grant", 32'(bus.dma_grant), 32'd0);
        @(negedge memclk);
        bus.dma_done = 1'b0;
        step();
        checkOutput("rereq_halt_n", 32'(bus.cpu_halt_n), 32'd0);
        checkOutput("rereq_grant", 32'(bus.dma_grant), 32'd0);

        // Dropping the request in HALT_WAIT hands the bus back to the CPU.
        @(negedge memclk);
        bus.dma_req = 1'b0;
        step();
        checkOutput("abort_halt_n", 32'(bus.cpu_halt_n), 32'd1);
        checkOutput("abort_grant", 32'(bus.dma_grant), 32'd0);

        // Control register: third write is blocked by the lock bit.
        bus.cpu_rw   = 1'b1;
        bus.cpu_addr = 16'h0480;
        doReset();
        begin
            logic [7:0] wr_data [3] = '{8'h02, 8'h07, 8'h00};
            logic [3:0] exp_ctrl [3] = '{4'h2, 4'h7, 4'h7};
            logic [1:0] exp_cnt [3] = '{2'd1, 2'd2, 2'd2};
            for (int i = 0; i < 3; i++) begin
                @(negedge memclk);
                bus.cpu_addr  = 16'h0001;
                bus.cpu_rw    = 1'b0;
                bus.cpu_wdata = wr_data[i];
                #1;
                checkOutput("ctrl_wr_dev_cs", 32'(bus.dev_cs), 32'd0);
                step();
                checkOutput($sformatf("ctrl_q[%0d]", i), 32'(ctrl_q), 32'(exp_ctrl[i]));
                checkOutput($sformatf("ctrl_writes[%0d]", i), 32'(ctrl_writes), 32'(exp_cnt[i]));
            end
        end
        @(negedge memclk);
        bus.cpu_rw   = 1'b1;
        bus.cpu_addr = 16'h0480;

        // Asynchronous reset in the middle of a DMA burst.
        bus.dma_req  = 1'b1;
        bus.cpu_sync = 1'b1;
        step();
        step();
        checkOutput("pre_reset_grant", 32'(bus.dma_grant), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_grant", 32'(bus.dma_grant), 32'd0);
        checkOutput("async_reset_halt_n", 32'(bus.cpu_halt_n), 32'd1);
        checkOutput("async_reset_ctrl_q", 32'(ctrl_q), 32'd0);
        checkOutput("async_reset_ctrl_writes", 32'(ctrl_writes), 32'd0);
        bus.dma_req  = 1'b0;
        bus.cpu_sync = 1'b0;
        @(negedge memclk);
        reset = 1'b0;
        step();
        checkOutput("post_reset_grant", 32'(bus.dma_grant), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
